load_store_unit: RTL

- Execute-stage data-memory unit, directly downstream of the ALU.
- Consumes the ALU adder result (ALU_ADD of rs1 + imm) as the effective address plus rs2 as store data, and runs the request/grant/response handshake with data memory.
- Returns aligned, sign- or zero-extended load data to writeback.
- One transaction outstanding at a time; the pipeline stalls on ready_o low.

---
 rtl/load_store_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Execute-stage load/store unit: drives the data-memory req/gnt/rvalid
// handshake and returns aligned, extended load data to writeback.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  sign_ext_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [DATA_WIDTH-1:0] data_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID
  } state_t;

  state_t state_q, state_d;

  logic [1:0]            off_q;
  logic [1:0]            size_q;
  logic                  sign_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  valid_q;
  logic                  err_q;

  logic                  misal;
  logic                  take;
  logic                  valid_d;
  logic                  err_d;
  logic [3:0]            be_n;
  logic [DATA_WIDTH-1:0] wdata_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ld_data;

  always_comb begin
    misal = 1'b0;
    unique case (1'b1)
      size_i == 2'b11: misal = 1'b1;
      size_i == 2'b10: misal = addr_i[1:0] != 2'b00;
      size_i == 2'b01: misal = addr_i[0];
      default:         misal = 1'b0;
    endcase
  end

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = wdata_i;
    unique case (1'b1)
      size_i == 2'b00: begin
        be_n    = 4'b0001 << addr_i[1:0];
        wdata_n = {4{wdata_i[7:0]}};
      end
      size_i == 2'b01: begin
        be_n    = 4'b0011 << addr_i[1:0];
        wdata_n = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign addr_n = {addr_i[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    data_req_o = 1'b0;
    take       = 1'b0;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          if (misal) begin
            err_d = 1'b1;
          end else begin
            data_req_o = 1'b1;
            take       = 1'b1;
            state_d    = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        data_req_o = 1'b1;
        if (data_gnt_i) state_d = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) begin
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus fields come straight from the inputs on the accept cycle,
  // then from the latched copy until the grant lands.
  assign data_addr_o  = take ? addr_n  : addr_q;
  assign data_we_o    = take ? we_i    : we_q;
  assign data_be_o    = take ? be_n    : be_q;
  assign data_wdata_o = take ? wdata_n : wdata_q;

  assign shifted = data_rdata_i >> {off_q, 3'b000};

  always_comb begin
    ld_data = shifted;
    unique case (1'b1)
      size_q == 2'b00:
        ld_data = {{24{sign_q & shifted[7]}}, shifted[7:0]};
      size_q == 2'b01:
        ld_data = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      off_q   <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      if (take) begin
        off_q   <= addr_i[1:0];
        size_q  <= size_i;
        sign_q  <= sign_ext_i;
        we_q    <= we_i;
        addr_q  <= addr_n;
        be_q    <= be_n;
        wdata_q <= wdata_n;
      end
      if (valid_d && !we_q) rdata_q <= ld_data;
    end
  end

  assign ready_o = state_q == IDLE;
  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

endmodule
